// File: rtl/window_fetch_seq.sv
// Sliding-window address sequencer: walks kc, kr, col, row, channel and emits a pixel address pair per beat.
// Optional beat counter on beat_cnt is enabled by defining WINDOW_FETCH_BEATCNT_EN.
module window_fetch_seq #(
  parameter int IMG_W    = 14,
  parameter int IMG_H    = 14,
  parameter int CH       = 16,
  parameter int K        = 3,
  parameter int STRIDE   = 1,
  parameter int PAIR_OFF = 2,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ready,
  output logic          valid,
  output logic [AW-1:0] addr1,
  output logic [AW-1:0] addr2,
  output logic [4:0]    row,
  output logic [4:0]    col,
  output logic [4:0]    channel,
  output logic          last,
  output logic          busy,
  output logic          done,
  output logic [15:0]   beat_cnt
);

  localparam int LAST_COL = ((IMG_W - K) / STRIDE) * STRIDE;
  localparam int LAST_ROW = ((IMG_H - K) / STRIDE) * STRIDE;
  localparam logic [4:0] STEP = 5'(STRIDE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     state_q;
  logic       valid_q, busy_q, done_q;
  logic [4:0] kc_q, kr_q, col_q, row_q, ch_q;
  logic [4:0] kc_d, kr_d, col_d, row_d, ch_d;
  logic       kc_end, kr_end, col_end, row_end, ch_end;
  logic       last_beat, accept;

  assign kc_end    = (kc_q  == 5'(K - 1));
  assign kr_end    = (kr_q  == 5'(K - 1));
  assign col_end   = (col_q == 5'(LAST_COL));
  assign row_end   = (row_q == 5'(LAST_ROW));
  assign ch_end    = (ch_q  == 5'(CH - 1));
  assign last_beat = kc_end & kr_end & col_end & row_end & ch_end;
  assign accept    = valid_q & ready;

  // Odometer carry chain; the final beat wraps every counter back to zero.
  always_comb begin
    kc_d  = kc_q;
    kr_d  = kr_q;
    col_d = col_q;
    row_d = row_q;
    ch_d  = ch_q;
    if (!kc_end) begin
      kc_d = kc_q + 5'd1;
    end else begin
      kc_d = '0;
      if (!kr_end) begin
        kr_d = kr_q + 5'd1;
      end else begin
        kr_d = '0;
        if (!col_end) begin
          col_d = col_q + STEP;
        end else begin
          col_d = '0;
          if (!row_end) begin
            row_d = row_q + STEP;
          end else begin
            row_d = '0;
            ch_d  = ch_end ? 5'd0 : ch_q + 5'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kc_q    <= '0;
      kr_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ch_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            kc_q    <= '0;
            kr_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            kc_q  <= kc_d;
            kr_q  <= kr_d;
            col_q <= col_d;
            row_q <= row_d;
            ch_q  <= ch_d;
            if (last_beat) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Address is formed at 32 bits and only then truncated, so wrap is modulo 2^AW.
  assign addr1   = AW'((32'(row_q) + 32'(kr_q)) * 32'(IMG_W) + 32'(col_q) + 32'(kc_q));
  assign addr2   = addr1 + AW'(PAIR_OFF);
  assign row     = row_q;
  assign col     = col_q;
  assign channel = ch_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign last    = valid_q & last_beat;

`ifdef WINDOW_FETCH_BEATCNT_EN
  logic [15:0] beat_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      beat_cnt_q <= '0;
    end else if (accept) begin
      beat_cnt_q <= beat_cnt_q + 16'd1;
    end
  end

  assign beat_cnt = beat_cnt_q;
`else
  assign beat_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_window_fetch_seq.sv
// Directed bench for window_fetch_seq: default-parameter instance plus a small 4x4/K2/S2/CH2 instance.
module tb_window_fetch_seq;

`ifdef WINDOW_FETCH_BEATCNT_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  localparam int TOTAL = 20736;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, ready = 1'b0;
  logic        valid, last, busy, done;
  logic [7:0]  addr1, addr2;
  logic [4:0]  row, col, channel;
  logic [15:0] beat_cnt;

  logic        start2 = 1'b0, ready2 = 1'b0;
  logic        valid2, last2, busy2, done2;
  logic [7:0]  addr1_2, addr2_2;
  logic [4:0]  row2, col2, channel2;
  logic [15:0] beat_cnt2;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  window_fetch_seq dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .valid(valid),
    .addr1(addr1), .addr2(addr2), .row(row), .col(col), .channel(channel),
    .last(last), .busy(busy), .done(done), .beat_cnt(beat_cnt)
  );

  window_fetch_seq #(.IMG_W(4), .IMG_H(4), .CH(2), .K(2), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .ready(ready2), .valid(valid2),
    .addr1(addr1_2), .addr2(addr2_2), .row(row2), .col(col2), .channel(channel2),
    .last(last2), .busy(busy2), .done(done2), .beat_cnt(beat_cnt2)
  );

  // Beat index -> address for the default geometry (K=3, OW=OH=12, IMG_W=14).
  function automatic int exp_addr(input int n);
    int kc, kr, c, r;
    kc = n % 3;
    kr = (n / 3) % 3;
    c  = (n / 9) % 12;
    r  = (n / 108) % 12;
    return ((r + kr) * 14 + c + kc) % 256;
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0; ready = 1'b0; start2 = 1'b0; ready2 = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vecs++; if ({valid, last, busy, done} !== 4'b0) begin errs++; $display("FAIL reset_flags got %b want 0000", {valid, last, busy, done}); end
    vecs++; if (addr1 !== 8'd0) begin errs++; $display("FAIL reset_addr1 got %0d want 0", addr1); end
    vecs++; if (addr2 !== 8'd2) begin errs++; $display("FAIL reset_addr2 got %0d want 2", addr2); end
    vecs++; if ({row, col, channel} !== 15'd0) begin errs++; $display("FAIL reset_pos got %0d/%0d/%0d want 0/0/0", row, col, channel); end
    vecs++; if (beat_cnt !== 16'd0) begin errs++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    vecs++; if ({valid, busy, done} !== 3'b0) begin errs++; $display("FAIL idle_flags got %b want 000", {valid, busy, done}); end
  endtask

  task automatic test_full_scan(input bit hold_start);
    int n, bad, cyc;
    n = 0; bad = 0; cyc = 0;
    @(negedge clk); start = 1'b1; ready = 1'b1;
    @(negedge clk); if (!hold_start) start = 1'b0;
    while (n < TOTAL && cyc < 30000) begin
      if (valid !== 1'b1) bad++;
      else begin
        if (addr1 !== 8'(exp_addr(n))) bad++;
        if (addr2 !== 8'(exp_addr(n) + 2)) bad++;
        if (channel !== 5'(n / 1296)) bad++;
        if (last !== (n == TOTAL - 1)) bad++;
        if (busy !== 1'b1 || done !== 1'b0) bad++;
        if (n == 0) begin
          vecs++; if (addr1 !== 8'd0 || addr2 !== 8'd2) begin errs++; $display("FAIL first_beat got %0d,%0d want 0,2", addr1, addr2); end
        end
        if (n == TOTAL - 1) begin
          vecs++; if (addr1 !== 8'd195 || addr2 !== 8'd197 || last !== 1'b1) begin errs++; $display("FAIL last_beat got %0d,%0d,last=%b want 195,197,1", addr1, addr2, last); end
        end
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    vecs++; if (n != TOTAL) begin errs++; $display("FAIL scan_beats got %0d want %0d", n, TOTAL); end
    vecs++; if (bad != 0) begin errs++; $display("FAIL scan_sequence got %0d bad beats want 0", bad); end
    vecs++; if ({done, valid, busy} !== 3'b100) begin errs++; $display("FAIL done_pulse got %b want 100", {done, valid, busy}); end
    vecs++; if (beat_cnt !== (BC ? 16'(TOTAL) : 16'd0)) begin errs++; $display("FAIL beat_cnt_done got %0d want %0d", beat_cnt, BC ? TOTAL : 0); end
    @(negedge clk);
    vecs++; if ({done, valid} !== 2'b00) begin errs++; $display("FAIL done_one_cycle got %b want 00", {done, valid}); end
    vecs++; if (beat_cnt !== (BC ? 16'(TOTAL) : 16'd0)) begin errs++; $display("FAIL beat_cnt_idle got %0d want %0d", beat_cnt, BC ? TOTAL : 0); end
    if (hold_start) begin
      @(negedge clk);
      vecs++; if (valid !== 1'b1 || addr1 !== 8'd0 || beat_cnt !== 16'd0) begin errs++; $display("FAIL restart_from_idle got v=%b a=%0d bc=%0d want 1,0,0", valid, addr1, beat_cnt); end
      start = 1'b0;
      do_reset();
    end
  endtask

  task automatic test_small_geom();
    int tbl[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    int n, cyc;
    n = 0; cyc = 0;
    @(negedge clk); start2 = 1'b1; ready2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    while (n < 32 && cyc < 100) begin
      if (valid2 === 1'b1) begin
        vecs++; if (addr1_2 !== 8'(tbl[n % 16]) || channel2 !== 5'(n / 16) || last2 !== (n == 31)) begin
          errs++; $display("FAIL small_beat%0d got a=%0d ch=%0d last=%b want a=%0d ch=%0d last=%b", n, addr1_2, channel2, last2, tbl[n % 16], n / 16, n == 31);
        end
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    vecs++; if (n != 32 || done2 !== 1'b1 || valid2 !== 1'b0) begin errs++; $display("FAIL small_end got beats=%0d done=%b valid=%b want 32,1,0", n, done2, valid2); end
    vecs++; if (beat_cnt2 !== (BC ? 16'd32 : 16'd0)) begin errs++; $display("FAIL small_beat_cnt got %0d want %0d", beat_cnt2, BC ? 32 : 0); end
    ready2 = 1'b0;
  endtask

  task automatic test_stall();
    int n, cyc, seq_bad, stall_bad, stalls;
    logic held;
    logic [7:0] s_a1, s_a2;
    logic [14:0] s_pos;
    logic s_last;
    n = 0; cyc = 0; seq_bad = 0; stall_bad = 0; stalls = 0; held = 1'b0;
    s_a1 = '0; s_a2 = '0; s_pos = '0; s_last = 1'b0;
    @(negedge clk); start = 1'b1; ready = 1'b0;
    @(negedge clk); start = 1'b0;
    while (n < 300 && cyc < 3000) begin
      if (held) begin
        stalls++;
        if (valid !== 1'b1 || addr1 !== s_a1 || addr2 !== s_a2 || {row, col, channel} !== s_pos || last !== s_last) stall_bad++;
      end
      if (valid === 1'b1) begin
        if (addr1 !== 8'(exp_addr(n)) || addr2 !== 8'(exp_addr(n) + 2)) seq_bad++;
        if (beat_cnt !== (BC ? 16'(n) : 16'd0)) seq_bad++;
      end
      ready = 1'($urandom_range(0, 1));
      if (valid === 1'b1 && ready) n++;
      held = (valid === 1'b1) && !ready;
      s_a1 = addr1; s_a2 = addr2; s_pos = {row, col, channel}; s_last = last;
      cyc++;
      @(negedge clk);
    end
    vecs++; if (n != 300) begin errs++; $display("FAIL stall_beats got %0d want 300", n); end
    vecs++; if (seq_bad != 0) begin errs++; $display("FAIL stall_sequence got %0d bad want 0", seq_bad); end
    vecs++; if (stall_bad != 0 || stalls == 0) begin errs++; $display("FAIL stall_frozen got %0d bad over %0d stalls want 0 bad", stall_bad, stalls); end
    do_reset();
  endtask

  task automatic test_reset_midrun();
    int n, cyc, done_seen;
    n = 0; cyc = 0; done_seen = 0;
    @(negedge clk); start = 1'b1; ready = 1'b1;
    @(negedge clk); start = 1'b0;
    while (n < 100 && cyc < 200) begin
      if (valid === 1'b1) n++;
      cyc++;
      @(negedge clk);
    end
    vecs++; if (valid !== 1'b1 || addr1 !== 8'(exp_addr(100))) begin errs++; $display("FAIL beat100 got v=%b a=%0d want 1,%0d", valid, addr1, exp_addr(100)); end
    #2 rst = 1'b1;
    #1;
    vecs++; if ({valid, last, busy, done} !== 4'b0 || addr1 !== 8'd0 || addr2 !== 8'd2) begin
      errs++; $display("FAIL async_reset got flags=%b a1=%0d a2=%0d want 0000,0,2", {valid, last, busy, done}, addr1, addr2);
    end
    vecs++; if ({row, col, channel} !== 15'd0 || beat_cnt !== 16'd0) begin errs++; $display("FAIL async_reset_pos got %0d/%0d/%0d bc=%0d want zeros", row, col, channel, beat_cnt); end
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1 || valid === 1'b1) done_seen++;
    end
    vecs++; if (done_seen != 0) begin errs++; $display("FAIL abort_no_done got %0d active cycles want 0", done_seen); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    vecs++; if (valid !== 1'b1 || addr1 !== 8'd0 || beat_cnt !== 16'd0) begin errs++; $display("FAIL restart got v=%b a=%0d bc=%0d want 1,0,0", valid, addr1, beat_cnt); end
    @(negedge clk);
    vecs++; if (addr1 !== 8'd1 || beat_cnt !== (BC ? 16'd1 : 16'd0)) begin errs++; $display("FAIL restart_beat1 got a=%0d bc=%0d want 1,%0d", addr1, beat_cnt, BC ? 1 : 0); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_full_scan(1'b0);
    test_small_geom();
    test_stall();
    test_reset_midrun();
    test_full_scan(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/window_fetch_seq.md
WINDOW_FETCH_SEQ -- requirements
Module: window_fetch_seq

Interface
REQ-001 SHALL have parameter IMG_W, default 14, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 14, image height in pixels.
REQ-003 SHALL have parameter CH, default 16, channel count.
REQ-004 SHALL have parameter K, default 3, square kernel size.
REQ-005 SHALL have parameter STRIDE, default 1, window step in rows and columns.
REQ-006 SHALL have parameter PAIR_OFF, default 2, offset of addr2 from addr1.
REQ-007 SHALL have parameter AW, default 8, address width.
REQ-008 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-009 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-010 SHALL have port start, input, 1 bit: begin a full scan.
REQ-011 SHALL have port ready, input, 1 bit: consumer accepts the current beat.
REQ-012 SHALL have port valid, output, 1 bit: addr1/addr2 hold a valid beat.
REQ-013 SHALL have port addr1, output, AW bits: pixel address (row+kr)*IMG_W+(col+kc).
REQ-014 SHALL have port addr2, output, AW bits: addr1+PAIR_OFF, modulo 2^AW.
REQ-015 SHALL have ports row, col, channel, output, 5 bits each: current window origin and channel.
REQ-016 SHALL have port last, output, 1 bit: high on the final beat of the scan.
REQ-017 SHALL have ports busy and done, output, 1 bit each: scan in progress; one-cycle completion pulse.
REQ-018 SHALL have port beat_cnt, output, 16 bits: accepted beats in the current or last scan.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on acceptance (valid&ready) of the last beat; DONE->IDLE unconditionally after one cycle.
REQ-020 SHALL ignore start while in RUN or DONE.
REQ-021 SHALL clear all counters (kc, kr, col, row, channel) on the IDLE->RUN transition.
REQ-022 SHALL assert valid in RUN only; busy is high in RUN; done is high in DONE only.
REQ-023 SHALL advance on each accepted beat in the order kc (fastest), kr, col, row, channel (slowest).
REQ-024 SHALL wrap kc and kr at K-1, col at the last origin (IMG_W-K) rounded down to a STRIDE multiple, and row likewise for IMG_H; col and row step by STRIDE.
REQ-025 SHALL hold all outputs stable while valid=1 and ready=0.
REQ-026 SHALL compute addr1 combinationally from registered counters at full width, then truncate to AW bits; zero-latency address relative to the counters.
REQ-027 SHALL assert last when all counters are at their final values and valid=1.
REQ-028 SHALL emit exactly CH*OH*OW*K*K beats per scan, with OH=(IMG_H-K)/STRIDE+1 and OW=(IMG_W-K)/STRIDE+1.

Reset
REQ-029 SHALL, on rst, enter IDLE immediately and drive valid, last, busy, done=0; addr1=0; addr2=PAIR_OFF; row, col, channel=0; beat_cnt=0.
REQ-030 SHALL abandon a scan when rst asserts mid-RUN, with no done pulse; the next start begins at beat 0.

Configuration
REQ-031 SHALL, with WINDOW_FETCH_BEATCNT_EN defined, count accepted beats in beat_cnt, clear it on IDLE->RUN, and hold it through DONE and IDLE.
REQ-032 SHALL, without WINDOW_FETCH_BEATCNT_EN, drive beat_cnt constant 0 and contain no counter logic.

Verification
REQ-033 SHALL cover: default params, start pulse, ready=1 -> first beat addr1=0, addr2=2; 20736 beats; last beat addr1=195, addr2=197; done is high 1 cycle after.
REQ-034 SHALL cover: IMG_W=IMG_H=4, K=2, STRIDE=2, CH=2, ready=1 -> addr1 sequence 0,1,4,5,2,3,6,7,8,...; 32 beats; channel=1 from beat 16.
REQ-035 SHALL cover: ready toggled randomly -> no address skipped or duplicated; outputs are frozen during each stall.
REQ-036 SHALL cover: rst asserted at beat 100 -> all outputs hit reset values asynchronously; restart yields addr1=0 and beat_cnt restarts at 0.
REQ-037 SHALL cover: start held high through RUN and DONE -> scan is not restarted early; a new scan starts only from IDLE.
REQ-038 SHALL cover: WINDOW_FETCH_BEATCNT_EN defined -> beat_cnt=20736 after the default scan; macro undefined -> beat_cnt=0 throughout.
